dma_apb_stream_responder: RTL and testbench

- APB completer (responder) that terminates one DMA APB stream channel: it is the peripheral end of the DMA's APB initiator.
- APB writes to the DATA register push into a TX FIFO that drains to a local valid/ready sink.
- APB reads of DATA pop an RX FIFO filled by a local valid/ready source.
- Provides programmable wait states and FIFO back-pressure through o_pready. Used as the bus-functional peripheral and as the base for stream peripherals.

---
 rtl/dma_apb_stream_responder.sv | 170 +++++++++++++++++
 tb/tb_dma_apb_stream_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_apb_stream_responder.sv
// APB completer terminating one DMA stream channel: DATA writes feed a TX FIFO
// toward a local sink, DATA reads drain an RX FIFO filled by a local source.
module dma_apb_stream_responder #(
  parameter int APB_ADDR_WIDTH  = 16,
  parameter int APB_DATA_WIDTH  = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int WAIT_CYCLES     = 0
) (
  input  logic                      pclk,
  input  logic                      pnreset,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic                      i_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
  input  logic [APB_DATA_WIDTH-1:0] i_pwdata,
  output logic                      o_pready,
  output logic [APB_DATA_WIDTH-1:0] o_prdata,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic [APB_DATA_WIDTH-1:0] o_tx_data,
  input  logic                      i_rx_valid,
  output logic                      o_rx_ready,
  input  logic [APB_DATA_WIDTH-1:0] i_rx_data
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0]      wait_q;
  logic [DW-1:0]   scratch_q;
  logic            pready_q;
  logic [DW-1:0]   prdata_q;

  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];
  logic [AW:0]     tx_wptr_q, tx_rptr_q, tx_wptr_d, tx_rptr_d;
  logic [AW:0]     rx_wptr_q, rx_rptr_q, rx_wptr_d, rx_rptr_d;

  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [1:0]      sel;
  logic            avail, complete;
  logic            tx_push, tx_pop, tx_flush;
  logic            rx_push, rx_pop, rx_flush;
  logic [DW-1:0]   rd_val;
  logic            unused_paddr;

  assign unused_paddr = ^{i_paddr[APB_ADDR_WIDTH-1:4], i_paddr[1:0]};

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

  assign sel   = i_paddr[3:2];
  assign avail = (sel != 2'd0) || (i_pwrite ? !tx_full : !rx_empty);

  // Completion is the single point where every side effect is applied.
  assign complete = (state_q == WAIT) && i_psel && i_penable &&
                    (cnt_q == 4'd0) && avail;

  assign tx_push  = complete && i_pwrite && (sel == 2'd0);
  assign rx_pop   = complete && !i_pwrite && (sel == 2'd0);
  assign tx_flush = complete && i_pwrite && (sel == 2'd2) && i_pwdata[4];
  assign rx_flush = complete && i_pwrite && (sel == 2'd2) && i_pwdata[5];
  assign tx_pop   = o_tx_valid && i_tx_ready;
  assign rx_push  = i_rx_valid && o_rx_ready;

  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_mem[tx_rptr_q[AW-1:0]];
  assign o_rx_ready = !rx_full;
  assign o_pready   = pready_q;
  assign o_prdata   = prdata_q;

  always_comb begin
    rd_val = '0;
    case (sel)
      2'd0: rd_val = rx_mem[rx_rptr_q[AW-1:0]];
      2'd1: rd_val[3:0] = {rx_empty, rx_full, tx_empty, tx_full};
      2'd2: rd_val[3:0] = wait_q;
      default: rd_val = scratch_q;
    endcase
  end

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
    end
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge pclk or negedge pnreset) begin
    if (!pnreset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= i_pwdata;
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge pclk or negedge pnreset) begin
    if (!pnreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wait_q    <= 4'(WAIT_CYCLES);
      scratch_q <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_psel && !i_penable) begin
            state_q <= WAIT;
            cnt_q   <= wait_q;
          end
        end
        WAIT: begin
          if (!i_psel) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (complete) begin
            state_q  <= RESP;
            pready_q <= 1'b1;
            if (i_pwrite) begin
              if (sel == 2'd2) wait_q <= i_pwdata[3:0];
              if (sel == 2'd3) scratch_q <= i_pwdata;
            end else begin
              prdata_q <= rd_val;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_apb_stream_responder.sv
// Directed bench for dma_apb_stream_responder: register access, latency,
// FIFO stalls, abort, flush and asynchronous reset during the response.
module tb_dma_apb_stream_responder;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          pclk = 1'b0;
  logic          pnreset;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] tx_data;
  logic          rx_valid, rx_ready;
  logic [DW-1:0] rx_data;

  int            errors = 0;
  int            checks = 0;
  int            lat;
  bit            got;
  logic [DW-1:0] rd;
  logic [DW-1:0] txq [$];

  always #5 pclk = ~pclk;

  dma_apb_stream_responder #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .FIFO_ADDR_WIDTH(4),
    .WAIT_CYCLES    (0)
  ) dut (
    .pclk      (pclk),
    .pnreset   (pnreset),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_paddr   (paddr),
    .i_pwdata  (pwdata),
    .o_pready  (pready),
    .o_prdata  (prdata),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_tx_data (tx_data),
    .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready),
    .i_rx_data (rx_data)
  );

  // Values seen here are the ones popped at the following rising edge.
  always @(negedge pclk)
    if (pnreset && tx_valid && tx_ready) txq.push_back(tx_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_start(input logic wr, input logic [1:0] idx, input logic [DW-1:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = {12'h0A0, idx, 2'b00}; pwdata = d;
    lat = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 1;
  endtask

  task automatic apb_wait(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge pclk); #1;
      lat++;
      if (pready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apb_end();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rw(input logic wr, input logic [1:0] idx, input logic [DW-1:0] d,
                        output logic [DW-1:0] rdata, output bit ok);
    apb_start(wr, idx, d);
    apb_wait(40, ok);
    rdata = prdata;
    apb_end();
  endtask

  initial begin
    pnreset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready",   {31'd0, pready},   32'd0);
    check("rst_prdata",   {16'd0, prdata},   32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    pnreset = 1'b1;

    // wait=0: two-cycle latency on SCRATCH write and read-back
    apb_rw(1'b1, 2'd3, 16'h5A5A, rd, got);
    check("scr_wr_done", {31'd0, got}, 32'd1);
    check("scr_wr_lat", lat, 32'd2);
    apb_rw(1'b0, 2'd3, '0, rd, got);
    check("scr_rd_lat", lat, 32'd2);
    check("scr_rd_data", {16'd0, rd}, 32'h5A5A);

    // wait=3 applies from the next transfer onward
    apb_rw(1'b1, 2'd2, 16'h0003, rd, got);
    check("ctrl_wr_lat", lat, 32'd2);
    apb_rw(1'b0, 2'd1, '0, rd, got);
    check("stat_lat_w3", lat, 32'd5);
    check("stat_empty", {16'd0, rd}, 32'h000A);
    apb_rw(1'b0, 2'd2, '0, rd, got);
    check("ctrl_rd", {16'd0, rd}, 32'h0003);

    // Fill TX to 16 entries with the sink held off
    for (int i = 1; i <= 16; i++) begin
      apb_rw(1'b1, 2'd0, DW'(i), rd, got);
      check("tx_fill_done", {31'd0, got}, 32'd1);
    end
    apb_rw(1'b0, 2'd1, '0, rd, got);
    check("stat_tx_full", {16'd0, rd}, 32'h0009);
    apb_start(1'b1, 2'd0, 16'd17);
    apb_wait(12, got);
    check("tx17_stall", {31'd0, got}, 32'd0);
    tx_ready = 1'b1;
    apb_wait(12, got);
    check("tx17_done", {31'd0, got}, 32'd1);
    apb_end();
    for (int i = 0; i < 60 && txq.size() < 17; i++) @(posedge pclk);
    #1;
    tx_ready = 1'b0;
    check("tx_drain_cnt", txq.size(), 32'd17);
    for (int i = 0; i < 17 && i < txq.size(); i++)
      check("tx_order", {16'd0, txq[i]}, 32'(i + 1));
    check("tx_valid_drained", {31'd0, tx_valid}, 32'd0);

    // DATA read on empty RX stalls until the source delivers
    apb_start(1'b0, 2'd0, '0);
    apb_wait(10, got);
    check("rx_empty_stall", {31'd0, got}, 32'd0);
    rx_valid = 1'b1; rx_data = 16'h00C3;
    @(posedge pclk); #1;
    rx_valid = 1'b0;
    apb_wait(10, got);
    check("rx_rd_done", {31'd0, got}, 32'd1);
    check("rx_rd_data", {16'd0, prdata}, 32'h00C3);
    apb_end();

    // Abort in WAIT with wait=5: no push
    apb_rw(1'b1, 2'd2, 16'h0005, rd, got);
    check("ctrl5_lat", lat, 32'd5);
    apb_start(1'b1, 2'd0, 16'h00AA);
    apb_wait(3, got);
    check("abort_no_ready", {31'd0, got}, 32'd0);
    apb_end();
    repeat (2) @(posedge pclk);
    #1;
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    apb_rw(1'b0, 2'd1, '0, rd, got);
    check("abort_stat_lat", lat, 32'd7);
    check("abort_stat", {16'd0, rd}, 32'h000A);

    // Back to wait=0, fill RX with three entries
    apb_rw(1'b1, 2'd2, 16'h0000, rd, got);
    check("ctrl0_lat", lat, 32'd7);
    rx_valid = 1'b1; rx_data = 16'h0011;
    @(posedge pclk); #1; rx_data = 16'h0022;
    @(posedge pclk); #1; rx_data = 16'h0033;
    @(posedge pclk); #1; rx_valid = 1'b0;
    apb_rw(1'b0, 2'd1, '0, rd, got);
    check("rx3_stat", {16'd0, rd}, 32'h0002);
    apb_rw(1'b0, 2'd0, '0, rd, got);
    check("rx_head", {16'd0, rd}, 32'h0011);

    // RX flush with the source still pushing
    rx_valid = 1'b1; rx_data = 16'h0044;
    apb_rw(1'b1, 2'd2, 16'h0020, rd, got);
    rx_valid = 1'b0;
    check("flush_done", {31'd0, got}, 32'd1);
    apb_rw(1'b0, 2'd2, '0, rd, got);
    check("ctrl_after_flush", {16'd0, rd}, 32'h0000);
    apb_rw(1'b0, 2'd1, '0, rd, got);
    check("stat_after_flush", {16'd0, rd}, 32'h000A);

    // Asynchronous reset while in RESP
    apb_start(1'b1, 2'd3, 16'hBEEF);
    apb_wait(10, got);
    check("pre_rst_ready", {31'd0, got}, 32'd1);
    pnreset = 1'b0;
    #1;
    check("rst_async_pready", {31'd0, pready}, 32'd0);
    check("rst_async_prdata", {16'd0, prdata}, 32'd0);
    apb_end();
    @(posedge pclk); #1;
    pnreset = 1'b1;
    apb_rw(1'b0, 2'd3, '0, rd, got);
    check("post_rst_scratch", {16'd0, rd}, 32'd0);
    check("post_rst_lat", lat, 32'd2);
    apb_rw(1'b0, 2'd2, '0, rd, got);
    check("post_rst_ctrl", {16'd0, rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
